ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 5000, clkin cycles kbclk is held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 1000000, clkin cycles allowed from request-to-send to ack sample (20 ms at 50 MHz).
REQ-003 clkin  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 kbclk  input  1  PS/2 clock line as read from the pad, asynchronous.
REQ-006 kbdata  input  1  PS/2 data line as read from the pad, asynchronous.
REQ-007 tx_start  input  1  one-cycle request to send tx_data.
REQ-008 tx_data  input  8  command byte (e.g. 0xED set-LEDs, 0xFF reset).
REQ-009 kbclk_oe  output  1  1 = pull kbclk low (open-drain); 0 = release.
REQ-010 kbdata_oe  output  1  1 = pull kbdata low (open-drain); 0 = release.
REQ-011 busy  output  1  high from accepted tx_start until done/err pulse.
REQ-012 done  output  1  one-cycle pulse, byte sent and acknowledged.
REQ-013 err  output  1  one-cycle pulse, missing ack or timeout.

Function
REQ-014 kbclk, kbdata pass through a 2-flop synchronizer; a falling edge is synced-kbclk 1 then 0 on consecutive cycles.
REQ-015 tx_start accepted only in IDLE; latches tx_data and odd parity (parity = ~^tx_data); ignored while busy.
REQ-016 States: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_REL; busy = state != IDLE.
REQ-017 INHIBIT: kbclk_oe=1, kbdata_oe=0 for exactly INHIBIT_CYC cycles, then RTS.
REQ-018 RTS: kbdata_oe=1 (start bit 0), kbclk_oe=0 from first RTS cycle; timeout counter cleared; next state SHIFT.
REQ-019 SHIFT: bit counter 0..9; on each falling kbclk edge present next bit: edges 1-8 data bits LSB first, edge 9 parity, edge 10 stop (kbdata_oe=0); kbdata_oe = ~bit, updated same cycle edge is detected.
REQ-020 After edge 10, state ACK; on edge 11 sample synced kbdata: 0 -> WAIT_REL, 1 -> err pulse, IDLE.
REQ-021 WAIT_REL: when synced kbclk and kbdata both 1, done pulse, IDLE.
REQ-022 Timeout counter runs in RTS, SHIFT, ACK, WAIT_REL; reaching TIMEOUT_CYC forces both oe=0, err pulse, IDLE; counter saturates, never wraps.
REQ-023 done and err never asserted in the same cycle; busy drops in the pulse cycle.
REQ-024 tx_start coincident with done/err pulse is ignored (state not yet IDLE).

Reset
REQ-025 rst=0 at a clkin edge: state IDLE, kbclk_oe=0, kbdata_oe=0, busy=0, done=0, err=0, counters 0, synchronizers to 1.
REQ-026 Reset mid-transfer releases both lines on the next clkin edge; no done/err emitted for the aborted byte.

Structure
REQ-027 Package ps2_pkg holds state encoding, INHIBIT_CYC/TIMEOUT_CYC defaults, command constants (CMD_SET_LED=8'hED, CMD_RESET=8'hFF).
REQ-028 Sub-module ps2_sync_edge (2-flop sync plus falling-edge detect), reused by the keyboard receiver.

Verification
REQ-029 tx_data=0xED, device model clocks 11 edges, ack low -> bits 1,0,1,1,0,1,1,1 then parity 1, stop 1; done after lines idle; err=0.
REQ-030 tx_data=0x07 -> parity bit 0 on edge 9; done pulse.
REQ-031 Device holds kbdata high on edge 11 -> err pulse one cycle, both oe=0, busy=0.
REQ-032 Device never clocks after RTS -> err exactly TIMEOUT_CYC cycles after RTS entry; lines released.
REQ-033 rst=0 during SHIFT after edge 4 -> next cycle kbclk_oe=0, kbdata_oe=0, busy=0; no done/err.
REQ-034 Second tx_start while busy -> ignored; only first byte transmitted, one done pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, timing defaults,
// keyboard command bytes and the frame parity helper.
package ps2_pkg;

    localparam int INHIBIT_CYC_DEF = 5000;
    localparam int TIMEOUT_CYC_DEF = 1000000;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INHIBIT  = 3'd1;
    localparam logic [2:0] ST_RTS      = 3'd2;
    localparam logic [2:0] ST_SHIFT    = 3'd3;
    localparam logic [2:0] ST_ACK      = 3'd4;
    localparam logic [2:0] ST_WAIT_REL = 3'd5;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 line plus a falling-edge
// strobe; shared between the host transmitter and the keyboard receiver.
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a command byte out on device clock edges and checks the ack bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       kbclk,
    input  logic       kbdata,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       kbclk_oe,
    output logic       kbdata_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);

    logic          clk_sync, clk_fall;
    logic          dat_meta_q, dat_sync_q;
    logic [2:0]    state_q, state_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] to_q, to_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    frame_q, frame_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          active;

    ps2_sync_edge u_clk_sync (
        .clk_i  (clkin),
        .rst_ni (rst),
        .line_i (kbclk),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    always_ff @(posedge clkin) begin
        if (!rst) begin
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            dat_meta_q <= kbdata;
            dat_sync_q <= dat_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        inh_d    = inh_q;
        to_d     = to_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        active   = (state_q == ST_RTS) || (state_q == ST_SHIFT) ||
                   (state_q == ST_ACK) || (state_q == ST_WAIT_REL);

        if (active) begin
            to_d = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // A start landing in a done/err pulse cycle belongs to the old transfer.
                if (tx_start && !done_q && !err_q) begin
                    frame_d  = {1'b1, odd_parity(tx_data), tx_data};
                    inh_d    = '0;
                    bit_d    = '0;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    to_d     = '0;
                    state_d  = ST_RTS;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            ST_RTS: state_d = ST_SHIFT;
            ST_SHIFT: begin
                // frame_q holds data LSB first, then parity, then the stop bit.
                if (clk_fall) begin
                    dat_oe_d = ~frame_q[bit_q];
                    if (bit_q == 4'd9) begin
                        state_d = ST_ACK;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (!dat_sync_q) begin
                        state_d = ST_WAIT_REL;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_REL: begin
                if (clk_sync && dat_sync_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout overrides whatever the protocol step decided this cycle.
        if (active && (to_q == TO_LAST)) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clkin) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            inh_q    <= '0;
            to_q     <= '0;
            bit_q    <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            inh_q    <= inh_d;
            to_q     <= to_d;
            bit_q    <= bit_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clkin) begin
        frame_q <= frame_d;
    end

    assign kbclk_oe  = clk_oe_q;
    assign kbdata_oe = dat_oe_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TMO = 500;

    logic       clkin = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       kbclk_oe, kbdata_oe, busy, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       kbclk, kbdata;

    assign kbclk  = ~(kbclk_oe | dev_clk_low);
    assign kbdata = ~(kbdata_oe | dev_data_low);

    always #5 clkin = ~clkin;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clkin     (clkin),
        .rst       (rst),
        .kbclk     (kbclk),
        .kbdata    (kbdata),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .kbclk_oe  (kbclk_oe),
        .kbdata_oe (kbdata_oe),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        bit         is_err;
        bit         chk_frame;
        logic [9:0] frame;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] dev_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         dev_edges = 11;
    bit         dev_ack = 1'b1;
    int         dev_half = 6;
    int         dev_edge_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Reference frame as the device sees it: 8 data bits LSB first, odd parity, stop.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = b[i];
        f[8] = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic push_exp(input bit is_err, input bit chk_frame, input logic [9:0] f);
        exp_t e;
        e.is_err = is_err;
        e.chk_frame = chk_frame;
        e.frame = f;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clkin);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clkin);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clkin);
            n++;
        end
        chk({name, "_idle"}, busy, 1'b0);
        repeat (4) @(negedge clkin);
    endtask

    task automatic xfer_ok(input string name, input logic [7:0] b);
        push_exp(1'b0, 1'b1, exp_frame(b));
        send(b);
        wait_idle(name);
    endtask

    initial forever begin
        @(posedge clkin);
        cyc++;
    end

    // Device model: waits for request-to-send, clocks the frame in, optionally acks.
    initial begin
        logic [9:0] cap;
        cap = '0;
        forever begin
            @(negedge clkin);
            if (rst && kbclk && !kbdata) begin
                dev_edge_cnt = 0;
                if (dev_edges > 0) begin
                    repeat (6) @(negedge clkin);
                    for (int e = 1; e <= dev_edges; e++) begin
                        dev_clk_low  = 1'b1;
                        dev_edge_cnt = e;
                        repeat (dev_half) @(negedge clkin);
                        if (e <= 10) cap[e-1] = kbdata;
                        dev_clk_low = 1'b0;
                        if (e == 10) begin
                            dev_q.push_back(cap);
                            if (dev_ack) dev_data_low = 1'b1;
                        end
                        repeat (dev_half) @(negedge clkin);
                    end
                    dev_data_low = 1'b0;
                end
                while (!(kbclk && kbdata)) @(negedge clkin);
            end
        end
    end

    // Scoreboard monitor: every done/err pulse consumes one expected outcome.
    initial begin
        exp_t       e;
        logic [9:0] got;
        forever begin
            @(negedge clkin);
            if (done && err) chk("done_err_exclusive", {done, err}, 2'b10);
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {done, err}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind_err", err, e.is_err);
                    chk("pulse_lines_busy", {kbclk_oe, kbdata_oe, busy}, 3'b000);
                    if (e.chk_frame) begin
                        if (dev_q.size() == 0) begin
                            chk("device_frame_present", 1'b0, 1'b1);
                        end else begin
                            got = dev_q.pop_front();
                            chk("frame_bits", got, e.frame);
                        end
                    end
                end
            end
        end
    end

    // Inhibit length and request-to-send line state, checked on every transfer.
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clkin);
            if (kbclk_oe) begin
                run++;
            end else if (run != 0) begin
                chk("inhibit_len", run, INH);
                if (rst) chk("rts_data_low", kbdata_oe, 1'b1);
                run = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 100000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         c0, c1, n;

        rst = 1'b0;
        repeat (3) @(negedge clkin);
        chk("rst_kbclk_oe", kbclk_oe, 1'b0);
        chk("rst_kbdata_oe", kbdata_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clkin);

        xfer_ok("set_led", CMD_SET_LED);
        xfer_ok("parity0", 8'h07);
        xfer_ok("cmd_reset", CMD_RESET);
        xfer_ok("zero", 8'h00);
        for (int i = 0; i < 6; i++) begin
            dev_half = $urandom_range(10, 5);
            b = 8'($urandom);
            xfer_ok("random", b);
        end
        dev_half = 6;

        // Device leaves the data line high on the ack edge.
        dev_ack = 1'b0;
        b = 8'($urandom);
        push_exp(1'b1, 1'b1, exp_frame(b));
        send(b);
        wait_idle("nack");
        dev_ack = 1'b1;

        // Device never clocks: err must arrive exactly TMO cycles after RTS entry.
        dev_edges = 0;
        push_exp(1'b1, 1'b0, '0);
        send(8'hA5);
        c0 = -1;
        c1 = -1;
        for (int i = 0; i < TMO + INH + 100; i++) begin
            @(negedge clkin);
            if (c0 < 0 && kbdata_oe) c0 = cyc;
            if (err) begin
                c1 = cyc;
                break;
            end
        end
        chk("timeout_seen", (c1 >= 0 && c0 >= 0), 1'b1);
        chk("timeout_cycles", c1 - c0, TMO);
        chk("timeout_lines", {kbclk_oe, kbdata_oe}, 2'b00);
        wait_idle("timeout");
        dev_edges = 11;

        // Reset after the fourth device clock edge aborts silently.
        dev_edges = 4;
        dev_edge_cnt = 0;
        send(8'h3C);
        n = 0;
        while (dev_edge_cnt != 4 && n < 2000) begin
            @(negedge clkin);
            n++;
        end
        chk("abort_edge4_reached", dev_edge_cnt, 4);
        repeat (4) @(negedge clkin);
        chk("abort_busy_before", busy, 1'b1);
        rst = 1'b0;
        @(negedge clkin);
        chk("abort_released", {kbclk_oe, kbdata_oe, busy, done, err}, 5'b00000);
        rst = 1'b1;
        repeat (80) @(negedge clkin);
        dev_edges = 11;

        // A second start while busy must not disturb the first byte.
        b = 8'($urandom);
        push_exp(1'b0, 1'b1, exp_frame(b));
        send(b);
        repeat (8) @(negedge clkin);
        send(~b);
        wait_idle("second_start");

        // A start coinciding with the done pulse is ignored.
        b = 8'($urandom);
        push_exp(1'b0, 1'b1, exp_frame(b));
        send(b);
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clkin);
            n++;
        end
        chk("coinc_done_seen", done, 1'b1);
        tx_data  = 8'($urandom);
        tx_start = 1'b1;
        @(negedge clkin);
        tx_start = 1'b0;
        chk("coinc_start_ignored", {busy, kbclk_oe}, 2'b00);
        repeat (INH + 20) @(negedge clkin);
        chk("coinc_still_idle", {busy, kbclk_oe}, 2'b00);

        repeat (10) @(negedge clkin);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("device_frames_drained", dev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
